muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file. It consumes the rs/rt read data on MULT/MULTU/DIV/DIVU/MTHI/MTLO, and returns HI/LO to the writeback mux for MFHI/MFLO. Operations are multi-cycle and use a start/busy/done handshake, so the control unit can stall on an MFHI/MFLO issued while busy.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 34 +++
 rtl/muldiv_sign_fix.sv | 45 ++++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - MIPS HI/LO op codes (MULT, MULTU, DIV, DIVU)
//   - FSM state encoding (IDLE -> CALC -> FIX -> IDLE)
//   - STEPS: number of radix-2 iterations per operation
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int STEPS = 32;
  localparam int CNT_W = $clog2(STEPS);

  // MULT and DIV treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Handshake / data bundle between the control unit + register file and the
// multiply/divide unit.
//   start, op, rs_data, rt_data, mthi, mtlo : requester -> unit
//   busy, done, hi, lo                      : unit -> requester
// Modports: master (control side), slave (muldiv_unit).
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign correction applied to the unsigned iteration result
// before it is written to HI/LO.
// Ports:
//   is_div  : 1 = acc holds {remainder, quotient}, 0 = acc holds product
//   neg_res : negate product / quotient (operand signs differ on a signed op)
//   neg_rem : negate remainder (signed divide with negative dividend)
//   div0    : divide by zero, quotient forced to all ones
//   acc     : 2*WIDTH unsigned result from the iteration
//   hi, lo  : corrected HI / LO values
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               div0,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    hi   = '0;
    lo   = '0;
    prod = neg_res ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // Remainder follows the dividend's sign; quotient follows sign XOR.
      lo = div0 ? '1 : (neg_res ? -quo : quo);
      hi = neg_rem ? -rem : rem;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO registers.
// An accepted start runs IDLE -> CALC (32 steps) -> FIX -> IDLE; done pulses
// for one cycle when HI/LO receive the new result (34 cycles after start).
// MTHI/MTLO write rs_data into HI/LO when idle and no start is requested.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (clears state, counter, operands, HI/LO)
//   bus  : muldiv_if.slave (start/op/rs_data/rt_data/mthi/mtlo in,
//          busy/done/hi/lo out)
//
// Build option:
//   MULDIV_EARLY_DONE_EN - when defined, MULT/MULTU with a multiplier magnitude
//   of 0 or 1 goes straight from IDLE to FIX (done 2 cycles after start).
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;

  // acc: multiply = {partial product, remaining multiplier bits}
  //      divide   = {partial remainder, dividend/quotient bits}
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               skip;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   r_diff;
  logic               ge;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand magnitudes for the op presented on the bus.
  always_comb begin
    sgn   = op_is_signed(bus.op);
    mag_a = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    mag_b = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  end

  always_comb begin
    skip = 1'b0;
`ifdef MULDIV_EARLY_DONE_EN
    skip = !bus.op[1] && (mag_b[WIDTH-1:1] == '0);
`else
    skip = 1'b0;
`endif
  end

  // One radix-2 iteration.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    r_sh     = acc[2*WIDTH-1:WIDTH-1];
    ge       = r_sh >= {1'b0, opnd};
    // When ge holds the difference is below the divisor, so WIDTH bits suffice.
    r_diff   = r_sh[WIDTH-1:0] - opnd;
    acc_step = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      acc_step = ge ? {r_diff, acc[WIDTH-2:0], 1'b1}
                    : {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div  (is_div),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .div0    (div0),
    .acc     (acc),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = skip ? FIX : CALC;
      CALC:    if (count == CNT_W'(STEPS - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count   <= '0;
            is_div  <= bus.op[1];
            neg_res <= sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            neg_rem <= sgn && bus.rs_data[WIDTH-1];
            div0    <= bus.op[1] && (bus.rt_data == '0);
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              // A skipped multiply already knows its product: 0 or mag_a.
              acc  <= skip ? {{WIDTH{1'b0}}, (mag_b[0] ? mag_a : {WIDTH{1'b0}})}
                           : {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else begin
            if (bus.mthi) hi_r <= bus.rs_data;
            if (bus.mtlo) lo_r <= bus.rs_data;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed-vector bench for muldiv_unit. Stimulus pushes the expected HI/LO of
// each operation into a scoreboard queue; a monitor pops and compares on every
// done pulse. Timing, reset and MTHI/MTLO behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare HI/LO against the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h, no result expected",
                 bus.hi, bus.lo);
      end else begin
        mon_e = sb.pop_front();
        check("result_hi", bus.hi, mon_e.hi);
        check("result_lo", bus.lo, mon_e.lo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit push, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      sb.push_back(e);
    end
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which done is seen.
  task automatic wait_done(input int first, output int lat, output int bcyc);
    lat  = first;
    bcyc = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcyc++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit chk_lat);
    int lat, bcyc;
    start_op(op, rs, rt, 1'b1, ehi, elo);
    wait_done(1, lat, bcyc);
    if (chk_lat) begin
      check({nm, "_latency"}, lat, 34);
      check({nm, "_busy_cycles"}, bcyc, 33);
    end else begin
      check({nm, "_done_seen"}, {31'd0, lat < 100}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bcyc, d0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    repeat (2) tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_op("mult_neg", OP_MULT, -32'sd3, 32'sd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    run_op("div_neg", OP_DIV, -32'sd7, 32'sd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op("div_negdiv", OP_DIV, 32'sd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("div_zero_neg", OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b1);
    run_op("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);

    // Start on the done cycle must be accepted.
    run_op("multu_a", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1'b1);
    run_op("multu_b2b", OP_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 1'b1);

    // Second start while busy is ignored.
    tick();
    d0 = n_done;
    start_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
    repeat (9) tick();
    bus.op      = OP_MULTU;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd5;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(11, lat, bcyc);
    check("ignore_start_latency", lat, 34);
    repeat (40) tick();
    check("ignore_start_one_done", n_done - d0, 1);

    // Reset in the middle of a DIVU abandons it.
    start_op(OP_DIVU, 32'd50, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    d0 = n_done;
    repeat (40) tick();
    check("midrst_no_done", n_done - d0, 0);
    run_op("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    tick();

    // MTHI / MTLO in idle.
    d0 = n_done;
    bus.rs_data = 32'h77;
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mt_both_hi", bus.hi, 32'h77);
    check("mt_both_lo", bus.lo, 32'h77);
    bus.rs_data = 32'hAAAA;
    bus.mthi    = 1'b1;
    tick();
    bus.mthi    = 1'b0;
    bus.rs_data = 32'h5555;
    bus.mtlo    = 1'b1;
    tick();
    bus.mtlo = 1'b0;
    check("mthi_hi", bus.hi, 32'hAAAA);
    check("mtlo_lo", bus.lo, 32'h5555);
    repeat (3) tick();
    check("mt_no_done", n_done - d0, 0);

    // MTLO while busy is ignored; HI/LO keep the previous result during CALC.
    start_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    repeat (4) tick();
    bus.rs_data = 32'h1234;
    bus.mtlo    = 1'b1;
    tick();
    bus.mtlo = 1'b0;
    check("mtlo_busy_lo", bus.lo, 32'h5555);
    check("mtlo_busy_hi", bus.hi, 32'hAAAA);
    wait_done(6, lat, bcyc);
    check("mtlo_busy_latency", lat, 34);
    tick();

    // MTLO together with start: the op wins, the MTLO is dropped.
    bus.mtlo = 1'b1;
    start_op(OP_MULTU, 32'd5, 32'd5, 1'b1, 32'd0, 32'd25);
    check("mtlo_start_lo", bus.lo, 32'd6);
    check("mtlo_start_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(1, lat, bcyc);
    check("mtlo_start_latency", lat, 34);

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
